digit_scan_ctrl: RTL and testbench
==================================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL provide one clock; reset is synchronous and active-low (clk, rst_n).
REQ-002 SHALL have parameter DWELL_CYC, default 50000: clock cycles each digit is shown; legal range >= 1.
REQ-003 SHALL have parameter BLANK_CYC, default 4: all-off cycles between digits; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-006 SHALL have port scan_en, input, 1 bit: scanning runs while high.
REQ-007 SHALL have port digit_mask, input, 8 bits: bit i=1 means digit i takes part in the scan.
REQ-008 SHALL have port sel, output, 3 bits: index of the current digit; drives the Sel input of the downstream 8:1 display-data mux.
REQ-009 SHALL have port mux_en, output, 1 bit: enable for the downstream mux; high only while a digit is shown.
REQ-010 SHALL have port an_n, output, 8 bits: active-low digit anodes; at most one bit low at any time.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-cycle pulse when the scan wraps to a new frame.

Function
REQ-012 SHALL register all outputs; no combinational path from an input to an output.
REQ-013 SHALL implement the FSM states IDLE, BLANK and SHOW, plus a dwell/blank counter wide enough for max(DWELL_CYC, BLANK_CYC).
REQ-014 In IDLE, SHALL hold mux_en=0 and an_n=8'hFF; sel holds its last value.
REQ-015 IDLE->BLANK SHALL occur when scan_en=1 and digit_mask!=0; sel SHALL load the lowest set bit index of digit_mask on that edge.
REQ-016 In BLANK, SHALL hold mux_en=0 and an_n=8'hFF for exactly BLANK_CYC cycles, then go to SHOW.
REQ-017 In SHOW, SHALL hold mux_en=1, an_n[sel]=0 and all other an_n bits 1, for exactly DWELL_CYC cycles.
REQ-018 At the end of SHOW, sel SHALL advance to the next set bit of digit_mask above sel, wrapping from 7 to 0; the FSM SHALL then go to BLANK.
REQ-019 On a wrapped advance (new index <= old index, including a single-bit mask), frame_tick SHALL be 1 for the first BLANK cycle only.
REQ-020 digit_mask SHALL be sampled only at IDLE exit and at SHOW end; a mask change mid-dwell SHALL NOT cut the current digit short.
REQ-021 If digit_mask=0 at SHOW end, SHALL go to IDLE with mux_en=0 and an_n=8'hFF on the next cycle, and no frame_tick.
REQ-022 scan_en=0 sampled in any state SHALL force IDLE on the next edge: mux_en=0, an_n=8'hFF, counter cleared. Re-enabling SHALL restart from the lowest set mask bit.
REQ-023 Latency: from scan_en sampled high in IDLE, the first an_n bit SHALL go low BLANK_CYC+1 edges later.
REQ-024 A full frame with k mask bits set SHALL last exactly k*(BLANK_CYC+DWELL_CYC) cycles between frame_tick pulses.
REQ-025 The downstream mux SHALL see stable sel for the whole interval in which mux_en=1.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set state=IDLE, counter=0, sel=3'b000, mux_en=0, an_n=8'hFF and frame_tick=0, in any state including mid-SHOW.
REQ-027 rst_n SHALL take priority over scan_en and every other input on the same edge.

Verification (DWELL_CYC=4, BLANK_CYC=2)
REQ-028 Reset, then scan_en=1, mask=8'hFF -> an_n=8'hFE 3 edges after enable, for 4 cycles. Digits 0..7 follow in order, each with 2 all-off cycles before it. frame_tick fires on the 7->0 advance, and the period is 48 cycles.
REQ-029 mask=8'b0010_0100 -> sel alternates 2,5,2,5. frame_tick fires on each 5->2 advance, and the period is 12 cycles.
REQ-030 mask=8'h08 -> sel stays 3, an_n toggles between 8'hF7 (4 cycles) and 8'hFF (2 cycles), and frame_tick fires every 6 cycles.
REQ-031 mask changed from 8'hFF to 8'h00 mid-SHOW of digit 2 -> digit 2 completes its 4 cycles, then IDLE: an_n=8'hFF, mux_en=0, no frame_tick.
REQ-032 scan_en dropped mid-SHOW of digit 4, then raised again 3 cycles later -> IDLE on the next edge, then restart at the lowest set mask bit after 2 blank cycles.
REQ-033 rst_n=0 for one cycle mid-SHOW of digit 6 -> all outputs at their REQ-026 values on the next edge, and an_n never has two bits low at once.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display digit scanner: walks the enabled digits of an 8-digit display,
// inserting an all-off blank gap before each digit and flagging each frame wrap.
//   state | meaning
//   IDLE  | scan stopped, all anodes off, sel holds
//   BLANK | all anodes off between digits, BLANK_CYC cycles
//   SHOW  | digit sel lit and mux enabled, DWELL_CYC cycles
module digit_scan_ctrl #(
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [7:0] digit_mask,
    output logic [2:0] sel,
    output logic       mux_en,
    output logic [7:0] an_n,
    output logic       frame_tick
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      sel_d, nxt_sel;
    logic            mux_en_d, tick_d;
    logic [7:0]      an_n_d;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Searches upward from cur+1, wrapping; offset 8 lands back on cur itself so a
    // single-bit mask re-selects the same digit.
    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = cur;
        for (int i = 8; i >= 1; i--) begin
            cand = cur + 3'(i);
            if (m[cand]) idx = cand;
        end
        return idx;
    endfunction

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sel_d    = sel;
        mux_en_d = 1'b0;
        an_n_d   = 8'hFF;
        tick_d   = 1'b0;
        nxt_sel  = next_set(digit_mask, sel);
        if (!scan_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (digit_mask != 8'h00) begin
                        state_d = BLANK;
                        sel_d   = lowest_set(digit_mask);
                        cnt_d   = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_d  = SHOW;
                        cnt_d    = DWELL_LOAD;
                        mux_en_d = 1'b1;
                        an_n_d   = ~(8'h01 << sel);
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == '0) begin
                        if (digit_mask == 8'h00) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = BLANK;
                            cnt_d   = BLANK_LOAD;
                            sel_d   = nxt_sel;
                            tick_d  = (nxt_sel <= sel);
                        end
                    end else begin
                        cnt_d    = cnt - CW'(1);
                        mux_en_d = 1'b1;
                        an_n_d   = ~(8'h01 << sel);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 3'd0;
            mux_en     <= 1'b0;
            an_n       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel        <= sel_d;
            mux_en     <= mux_en_d;
            an_n       <= an_n_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl (DWELL_CYC=4, BLANK_CYC=2): stimulus queues the
// expected digit shows and frame periods, a negedge monitor consumes and compares them.
module tb_digit_scan_ctrl;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_en = 1'b0;
    logic [7:0] digit_mask = 8'h00;
    logic [2:0] sel;
    logic       mux_en;
    logic [7:0] an_n;
    logic       frame_tick;

    digit_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .digit_mask(digit_mask),
        .sel       (sel),
        .mux_en    (mux_en),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] an_n;
        int         len;
    } show_t;

    show_t exp_q[$];
    int    tick_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 1'b0;
    int    cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_show(input logic [2:0] s, input logic [7:0] a, input int len);
        show_t e;
        e.sel = s;
        e.an_n = a;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Edges from the first edge that samples scan_en high until an anode goes low.
    task automatic measure_latency(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (an_n == 8'hFF && n < 20);
    endtask

    // Monitor
    bit         in_show = 1'b0;
    bit         have_cur = 1'b0;
    show_t      cur;
    int         show_len = 0;
    logic [2:0] show_sel = 3'd0;
    int         last_tick = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            checks++;
            if ($countones(~an_n) > 1 || mux_en != (an_n != 8'hFF)) begin
                errors++;
                $display("FAIL anode_onehot actual an_n=%h mux_en=%b required at most one low, mux_en iff lit", an_n, mux_en);
            end
            if (mux_en) begin
                if (!in_show) begin
                    in_show = 1'b1;
                    show_len = 1;
                    show_sel = sel;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_show actual sel=%0d required no show", sel);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        if (sel !== cur.sel || an_n !== cur.an_n) begin
                            errors++;
                            $display("FAIL show_digit actual sel=%0d an_n=%h required sel=%0d an_n=%h",
                                     sel, an_n, cur.sel, cur.an_n);
                        end
                    end
                end else begin
                    show_len++;
                    checks++;
                    if (sel !== show_sel) begin
                        errors++;
                        $display("FAIL sel_stable actual=%0d required=%0d", sel, show_sel);
                    end
                end
            end else if (in_show) begin
                in_show = 1'b0;
                if (have_cur) begin
                    checks++;
                    if (show_len != cur.len) begin
                        errors++;
                        $display("FAIL dwell_len sel=%0d actual=%0d required=%0d", cur.sel, show_len, cur.len);
                    end
                end
            end
            if (frame_tick) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    int p;
                    p = tick_q.pop_front();
                    if (an_n != 8'hFF) begin
                        errors++;
                        $display("FAIL tick_in_blank actual an_n=%h required FF", an_n);
                    end
                    if (p != 0 && (cyc - last_tick) != p) begin
                        errors++;
                        $display("FAIL frame_period actual=%0d required=%0d", cyc - last_tick, p);
                    end
                end
                last_tick = cyc;
            end
        end
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_mux_en", 32'(mux_en), 32'd0);
        check("reset_an_n", 32'(an_n), 32'hFF);
        check("reset_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All eight digits, two full frames
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) push_show(3'(i), ~(8'h01 << i), DW);
        tick_q.push_back(0);
        tick_q.push_back(48);
        digit_mask = 8'hFF;
        scan_en = 1'b1;
        measure_latency(lat);
        check("latency_ff", 32'(lat), 32'd3);
        check("first_an_n", 32'(an_n), 32'hFE);
        repeat (94) @(posedge clk);
        #1 scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_an_n", 32'(an_n), 32'hFF);
        check("idle_sel_hold", 32'(sel), 32'd0);

        // Digits 2 and 5 alternate
        push_show(3'd2, 8'hFB, DW);
        push_show(3'd5, 8'hDF, DW);
        push_show(3'd2, 8'hFB, DW);
        push_show(3'd5, 8'hDF, DW);
        tick_q.push_back(0);
        tick_q.push_back(12);
        digit_mask = 8'b0010_0100;
        scan_en = 1'b1;
        repeat (25) @(posedge clk);
        #1 scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single digit 3
        push_show(3'd3, 8'hF7, DW);
        push_show(3'd3, 8'hF7, DW);
        push_show(3'd3, 8'hF7, DW);
        tick_q.push_back(0);
        tick_q.push_back(6);
        tick_q.push_back(6);
        digit_mask = 8'h08;
        scan_en = 1'b1;
        repeat (19) @(posedge clk);
        #1 scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Mask cleared mid-show of digit 2
        push_show(3'd0, 8'hFE, DW);
        push_show(3'd1, 8'hFD, DW);
        push_show(3'd2, 8'hFB, DW);
        digit_mask = 8'hFF;
        scan_en = 1'b1;
        repeat (16) @(posedge clk);
        #1 digit_mask = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("mask0_still_showing", 32'(an_n), 32'hFB);
        @(posedge clk);
        #1;
        check("mask0_idle_an_n", 32'(an_n), 32'hFF);
        check("mask0_idle_mux_en", 32'(mux_en), 32'd0);
        check("mask0_sel_hold", 32'(sel), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("mask0_no_tick", 32'(frame_tick), 32'd0);
        end
        scan_en = 1'b0;
        digit_mask = 8'hFF;
        repeat (2) @(posedge clk);
        #1;

        // scan_en dropped mid-show of digit 4, restart, then reset mid-show of digit 6
        for (int i = 0; i < 4; i++) push_show(3'(i), ~(8'h01 << i), DW);
        push_show(3'd4, 8'hEF, 2);
        for (int i = 0; i < 6; i++) push_show(3'(i), ~(8'h01 << i), DW);
        push_show(3'd6, 8'hBF, 2);
        scan_en = 1'b1;
        repeat (28) @(posedge clk);
        #1 scan_en = 1'b0;
        @(posedge clk);
        #1;
        check("drop_an_n", 32'(an_n), 32'hFF);
        check("drop_mux_en", 32'(mux_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 scan_en = 1'b1;
        measure_latency(lat);
        check("restart_latency", 32'(lat), 32'd3);
        check("restart_an_n", 32'(an_n), 32'hFE);
        repeat (37) @(posedge clk);
        #1;
        check("pre_reset_an_n", 32'(an_n), 32'hBF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_mux_en", 32'(mux_en), 32'd0);
        check("rst_an_n", 32'(an_n), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        scan_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pending_shows", 32'(exp_q.size()), 32'd0);
        check("pending_ticks", 32'(tick_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
